// File: rtl/ray_gen.sv
// ray_gen: per-frame primary-ray generator.
// Scans every pixel of a frame in raster order after a start pulse. For each
// pixel it emits one AXI-stream beat with a float32 ray direction
// (x = h - H/2, y = V/2 - v, z = -FOCAL), the pixel column/row and the
// object-select mask latched at start.
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   start                 frame start pulse, only honoured in IDLE
//   select_objs_in[1:0]   object mask sampled on an accepted start
//   ray_axis_tdata        {z, y, x} float32 ray direction
//   hcount/vcount_axis_tdata  pixel column / row of the beat
//   select_objs           latched mask
//   ray_axis_tvalid/tready    output stream handshake
//   busy                  frame in progress
//   frame_done            one-cycle pulse after the last accepted beat
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start, both pipeline stages empty
// RUN   | loading pixels into stage A in raster order
// DRAIN | last pixel loaded, waiting for stages A and B to empty

module ray_gen #(
   parameter int SIZE     = 32,
   parameter int H_PIXELS = 320,
   parameter int V_PIXELS = 180,
   parameter int FOCAL    = 256
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic                start,
   input  logic [1:0]          select_objs_in,
   output logic [3*SIZE-1:0]   ray_axis_tdata,
   output logic [10:0]         hcount_axis_tdata,
   output logic [9:0]          vcount_axis_tdata,
   output logic [1:0]          select_objs,
   output logic                ray_axis_tvalid,
   input  logic                ray_axis_tready,
   output logic                busy,
   output logic                frame_done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t             state_q, state_d;
   logic [10:0]        h_q, h_d;
   logic [9:0]         v_q, v_d;
   logic [1:0]         mask_q, mask_d;

   logic               a_valid_q, a_valid_d;
   logic signed [11:0] a_x_q, a_x_d;
   logic signed [11:0] a_y_q, a_y_d;
   logic signed [11:0] a_z_q, a_z_d;
   logic [10:0]        a_h_q, a_h_d;
   logic [9:0]         a_v_q, a_v_d;

   logic               b_valid_q, b_valid_d;
   logic [3*SIZE-1:0]  ray_q, ray_d;
   logic [10:0]        hc_q, hc_d;
   logic [9:0]         vc_q, vc_d;

   logic               frame_done_q, frame_done_d;
   logic               b_load;
   logic               a_take;

   // Exact int -> float32: all legal magnitudes fit in 12 bits, far below the
   // 24-bit significand, so the bits below the MSB are simply left-aligned.
   function automatic logic [31:0] to_f32(input logic signed [11:0] val);
      logic [11:0] mag;
      logic [3:0]  p;
      logic [22:0] mant;
      mag = val[11] ? 12'(-val) : 12'(val);
      p   = 4'd0;
      for (int i = 0; i < 12; i++) begin
         if (mag[i]) p = 4'(i);
      end
      mant = 23'({mag, 23'd0} >> p);
      if (mag == 12'd0) return 32'h0000_0000;
      return {val[11], 8'(8'd127 + {4'd0, p}), mant};
   endfunction

   always_comb begin
      state_d      = state_q;
      h_d          = h_q;
      v_d          = v_q;
      mask_d       = mask_q;
      a_valid_d    = a_valid_q;
      a_x_d        = a_x_q;
      a_y_d        = a_y_q;
      a_z_d        = a_z_q;
      a_h_d        = a_h_q;
      a_v_d        = a_v_q;
      b_valid_d    = b_valid_q;
      ray_d        = ray_q;
      hc_d         = hc_q;
      vc_d         = vc_q;
      frame_done_d = 1'b0;

      b_load = !b_valid_q || ray_axis_tready;
      // Stage A is free next cycle if it is empty or its pixel moves to B now.
      a_take = b_load || !a_valid_q;

      if (b_load) begin
         b_valid_d = a_valid_q;
         if (a_valid_q) begin
            ray_d = {to_f32(a_z_q), to_f32(a_y_q), to_f32(a_x_q)};
            hc_d  = a_h_q;
            vc_d  = a_v_q;
         end
      end

      if (a_take) a_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               h_d     = '0;
               v_d     = '0;
               mask_d  = select_objs_in;
            end
         end
         RUN: begin
            if (a_take) begin
               a_valid_d = 1'b1;
               a_x_d     = 12'(h_q) - 12'(H_PIXELS / 2);
               a_y_d     = 12'(V_PIXELS / 2) - 12'(v_q);
               a_z_d     = 12'd0 - 12'(FOCAL);
               a_h_d     = h_q;
               a_v_d     = v_q;
               if (h_q == 11'(H_PIXELS - 1)) begin
                  h_d = '0;
                  if (v_q == 10'(V_PIXELS - 1)) begin
                     v_d     = '0;
                     state_d = DRAIN;
                  end else begin
                     v_d = v_q + 10'd1;
                  end
               end else begin
                  h_d = h_q + 11'd1;
               end
            end
         end
         DRAIN: begin
            // Leave on the edge that accepts the final beat so frame_done
            // lands in the very next cycle.
            if (!a_valid_d && !b_valid_d) begin
               state_d      = IDLE;
               frame_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q      <= IDLE;
         h_q          <= '0;
         v_q          <= '0;
         mask_q       <= '0;
         a_valid_q    <= 1'b0;
         a_x_q        <= '0;
         a_y_q        <= '0;
         a_z_q        <= '0;
         a_h_q        <= '0;
         a_v_q        <= '0;
         b_valid_q    <= 1'b0;
         ray_q        <= '0;
         hc_q         <= '0;
         vc_q         <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         h_q          <= h_d;
         v_q          <= v_d;
         mask_q       <= mask_d;
         a_valid_q    <= a_valid_d;
         a_x_q        <= a_x_d;
         a_y_q        <= a_y_d;
         a_z_q        <= a_z_d;
         a_h_q        <= a_h_d;
         a_v_q        <= a_v_d;
         b_valid_q    <= b_valid_d;
         ray_q        <= ray_d;
         hc_q         <= hc_d;
         vc_q         <= vc_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign ray_axis_tdata    = ray_q;
   assign hcount_axis_tdata = hc_q;
   assign vcount_axis_tdata = vc_q;
   assign select_objs       = mask_q;
   assign ray_axis_tvalid   = b_valid_q;
   assign busy              = (state_q != IDLE);
   assign frame_done        = frame_done_q;

endmodule

// File: tb/tb_ray_gen.sv
// Bench for ray_gen. Uses H=320 (so the hand-computed x corners apply) with a
// short V=6 frame to keep every full-frame scenario small.
module tb_ray_gen;

   localparam int H  = 320;
   localparam int V  = 6;
   localparam int F  = 256;
   localparam int NB = H * V;

   logic        aclk = 1'b0;
   logic        areset;
   logic        start;
   logic [1:0]  select_objs_in;
   logic [95:0] ray_axis_tdata;
   logic [10:0] hcount_axis_tdata;
   logic [9:0]  vcount_axis_tdata;
   logic [1:0]  select_objs;
   logic        ray_axis_tvalid;
   logic        ray_axis_tready;
   logic        busy;
   logic        frame_done;

   ray_gen #(.SIZE(32), .H_PIXELS(H), .V_PIXELS(V), .FOCAL(F)) dut (
      .aclk              (aclk),
      .areset            (areset),
      .start             (start),
      .select_objs_in    (select_objs_in),
      .ray_axis_tdata    (ray_axis_tdata),
      .hcount_axis_tdata (hcount_axis_tdata),
      .vcount_axis_tdata (vcount_axis_tdata),
      .select_objs       (select_objs),
      .ray_axis_tvalid   (ray_axis_tvalid),
      .ray_axis_tready   (ray_axis_tready),
      .busy              (busy),
      .frame_done        (frame_done)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      int          h;
      int          v;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
   } vec_t;

   vec_t vecs[5];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int beat_idx, done_cnt, stall_cnt, tbl_hits, last_acc_cyc, done_cyc, start_cyc;
   logic         mon_en = 1'b0;
   logic         bp_en = 1'b0;
   logic         stalled_prev;
   logic [118:0] held;
   logic [1:0]   exp_mask;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference conversion through the double-precision encoding.
   function automatic logic [31:0] ref_f32(input int val);
      real         r;
      logic [63:0] d;
      if (val == 0) return 32'h0;
      r = val;
      d = $realtobits(r);
      return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
   endfunction

   task automatic clear_mon();
      beat_idx = 0; done_cnt = 0; stall_cnt = 0; tbl_hits = 0;
      stalled_prev = 1'b0; last_acc_cyc = -10;
   endtask

   task automatic do_start(input logic [1:0] m);
      @(posedge aclk); #1;
      start = 1'b1; select_objs_in = m; start_cyc = cyc;
      @(posedge aclk); #1;
      start = 1'b0; select_objs_in = 2'b00;
      check("busy_rise", busy, 1'b1);
      check("tvalid_lat1", ray_axis_tvalid, 1'b0);
      @(posedge aclk); #1;
      check("tvalid_lat2", ray_axis_tvalid, 1'b0);
      @(posedge aclk); #1;
      check("tvalid_lat3", ray_axis_tvalid, 1'b1);
   endtask

   task automatic wait_beats(input int n);
      int k = 0;
      while (beat_idx < n && k < 10000) begin @(posedge aclk); k++; end
      check("beat_reach", beat_idx >= n, 1'b1);
   endtask

   task automatic wait_done_and_check();
      int k = 0;
      while (done_cnt == 0 && k < 10000) begin @(posedge aclk); k++; end
      check("frame_done_seen", done_cnt > 0, 1'b1);
      repeat (5) @(posedge aclk);
      check("frame_done_once", done_cnt, 1);
      check("beat_total", beat_idx, NB);
      check("frame_len", done_cyc - start_cyc, 3 + NB + stall_cnt);
      check("table_hits", tbl_hits, 5);
   endtask

   initial forever begin
      @(posedge aclk);
      cyc++;
   end

   initial begin
      ray_axis_tready = 1'b1;
      forever begin
         @(posedge aclk); #1;
         ray_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Stream monitor: raster-order model, hand table, stall stability, frame_done timing.
   initial forever begin
      @(negedge aclk);
      if (mon_en) begin
         if (stalled_prev)
            check("stall_stable",
                  {ray_axis_tdata, hcount_axis_tdata, vcount_axis_tdata, select_objs}, held);
         if (ray_axis_tvalid) begin
            if (ray_axis_tready) begin
               int eh, ev;
               eh = beat_idx % H;
               ev = beat_idx / H;
               check("beat_h", hcount_axis_tdata, eh);
               check("beat_v", vcount_axis_tdata, ev);
               check("beat_ray", ray_axis_tdata,
                     {ref_f32(-F), ref_f32(V / 2 - ev), ref_f32(eh - H / 2)});
               check("beat_mask", select_objs, exp_mask);
               for (int i = 0; i < 5; i++) begin
                  if (vecs[i].h == eh && vecs[i].v == ev) begin
                     tbl_hits++;
                     check("tbl_x", ray_axis_tdata[31:0], vecs[i].x);
                     check("tbl_y", ray_axis_tdata[63:32], vecs[i].y);
                     check("tbl_z", ray_axis_tdata[95:64], vecs[i].z);
                  end
               end
               last_acc_cyc = cyc;
               beat_idx++;
            end else begin
               stall_cnt++;
            end
         end
         stalled_prev = ray_axis_tvalid && !ray_axis_tready;
         held = {ray_axis_tdata, hcount_axis_tdata, vcount_axis_tdata, select_objs};
         if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_after_last", cyc, last_acc_cyc + 1);
            check("done_busy_low", busy, 1'b0);
            check("done_beats", beat_idx, NB);
         end
      end
   end

   initial begin
      vecs[0] = '{h: 0,   v: 0, x: 32'hC320_0000, y: 32'h4040_0000, z: 32'hC380_0000};
      vecs[1] = '{h: 160, v: 1, x: 32'h0000_0000, y: 32'h4000_0000, z: 32'hC380_0000};
      vecs[2] = '{h: 319, v: 3, x: 32'h431F_0000, y: 32'h0000_0000, z: 32'hC380_0000};
      vecs[3] = '{h: 1,   v: 4, x: 32'hC31F_0000, y: 32'hBF80_0000, z: 32'hC380_0000};
      vecs[4] = '{h: 319, v: 5, x: 32'h431F_0000, y: 32'hC000_0000, z: 32'hC380_0000};

      areset = 1'b1; start = 1'b0; select_objs_in = 2'b00;
      repeat (3) @(posedge aclk);
      #1 areset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         check("idle_outputs",
               {ray_axis_tvalid, busy, frame_done, select_objs,
                hcount_axis_tdata, vcount_axis_tdata, ray_axis_tdata}, '0);
      end

      // Full frame, tready high throughout.
      clear_mon(); exp_mask = 2'b11; mon_en = 1'b1;
      do_start(2'b11);
      wait_done_and_check();

      // Random backpressure, mask 01, ignored start with mask 10 mid-frame.
      clear_mon(); exp_mask = 2'b01; bp_en = 1'b1;
      do_start(2'b01);
      wait_beats(500);
      @(posedge aclk); #1;
      start = 1'b1; select_objs_in = 2'b10;
      @(posedge aclk); #1;
      start = 1'b0; select_objs_in = 2'b00;
      wait_done_and_check();
      check("stalls_seen", stall_cnt > 0, 1'b1);
      bp_en = 1'b0;

      // Reset at beat 1000: frame abandoned without frame_done.
      clear_mon(); exp_mask = 2'b10;
      do_start(2'b10);
      wait_beats(1000);
      @(posedge aclk); #1;
      areset = 1'b1; mon_en = 1'b0;
      @(posedge aclk); #1;
      areset = 1'b0;
      check("rst_tvalid", ray_axis_tvalid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", frame_done, 1'b0);
      check("rst_mask", select_objs, 2'b00);
      check("rst_no_done", done_cnt, 0);
      repeat (5) @(posedge aclk); #1;
      check("rst_quiet", {frame_done, busy, ray_axis_tvalid}, 3'b000);

      // Fresh frame after the abort must start again at pixel (0,0).
      clear_mon(); exp_mask = 2'b10; mon_en = 1'b1;
      do_start(2'b10);
      wait_done_and_check();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ray_gen.md
# ray_gen

Per-frame primary-ray generator that sits directly upstream of the object-intersection stage. On a `start` pulse it scans every pixel in raster order. For each pixel it emits one AXI-stream beat carrying a float32 ray direction, the pixel's hcount/vcount, and the object-select mask. Its outputs connect one-to-one to the intersection stage's ray, hcount, vcount and select inputs, and it honours that stage's `tready` backpressure.

## Interface
Parameters:
- `SIZE`, 32: float width. Only 32 (IEEE-754 single) is supported.
- `H_PIXELS`, 320: pixels per line, 2..2047.
- `V_PIXELS`, 180: lines per frame, 2..1023.
- `FOCAL`, 256: image-plane distance in pixel units, 1..2047.

Ports:
- `aclk`  in  1  clock; single clock domain.
- `areset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a frame. Ignored unless the block is in IDLE.
- `select_objs_in`  in  2  object mask, sampled on an accepted `start`. Bit 1 selects the sphere; bit 0 selects the cylinders.
- `ray_axis_tdata`  out  3×SIZE  ray direction: [0]=x, [1]=y, [2]=z.
- `hcount_axis_tdata`  out  11  pixel column of the current beat.
- `vcount_axis_tdata`  out  10  pixel row of the current beat.
- `select_objs`  out  2  latched mask, constant for the whole frame.
- `ray_axis_tvalid`  out  1  beat valid.
- `ray_axis_tready`  in  1  downstream accepts the beat.
- `busy`  out  1  high from an accepted `start` until `frame_done`.
- `frame_done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE to RUN on `start`. Clears h=0, v=0 and latches `select_objs_in`.
  - RUN to DRAIN once pixel (H_PIXELS-1, V_PIXELS-1) has been loaded into stage A.
  - DRAIN to IDLE once stages A and B are both empty. `frame_done` pulses in the same cycle the state returns to IDLE.
- Counters:
  - h increments on each stage-A load and wraps to 0 at H_PIXELS-1.
  - v increments on each h wrap.
  - There is no wrap of v: the frame ends after the last pixel.
- Stage A (integer) registers:
  - x = h − H_PIXELS/2, as a 12-bit signed integer (integer division).
  - y = V_PIXELS/2 − v.
  - z = −FOCAL.
  - h, v and a valid bit.
- Stage B (output) registers:
  - Converts x, y and z to float32 and registers them onto `ray_axis_tdata`, with hcount/vcount and `tvalid`.
  - Conversion:
    - Sign bit = integer sign.
    - Magnitude = |int|. Locate its MSB position p.
    - Exponent = 127+p.
    - Mantissa = the bits below the MSB, left-aligned into 23 bits.
    - An integer of 0 gives 32'h00000000.
  - The conversion is exact for all legal ranges; no rounding is needed.
- Elastic handshake:
  - Stage B loads when it is empty or its beat is accepted (`tvalid && tready`).
  - Stage A loads a new pixel when stage B can take stage A's contents or stage A is empty.
  - No beat is dropped or duplicated. Pixel order is strictly raster.
- While `tvalid && !tready`, all output data holds stable.
- `start` while busy: ignored, with no effect on counters or the mask.
- Reset mid-frame: the state returns to IDLE, both stages are emptied, and the frame is abandoned with no `frame_done`.

## Timing
- Reset values:
  - IDLE state.
  - h, v = 0.
  - `ray_axis_tvalid`, `busy` and `frame_done` = 0.
  - `ray_axis_tdata`, `hcount_axis_tdata`, `vcount_axis_tdata` and `select_objs` = 0.
- `busy` rises in the cycle after `start`.
- Latency: the first `tvalid` is asserted 3 cycles after the `start` cycle (state register, stage A, stage B).
- With `tready` held high, the block issues one beat per cycle and H_PIXELS·V_PIXELS consecutive beats.
- Timing of `frame_done`:
  - It pulses the cycle after the final accepted beat.
  - `busy` falls in that same cycle.
  - A new `start` is accepted in that cycle or later.
- Stalls:
  - `tready` low for N cycles extends the frame by exactly N cycles.
  - At most 2 pixels are in flight.

## Test plan
- **Reset/idle:** assert `areset` for 3 cycles, hold `start`=0 for 20 cycles. All outputs stay 0 and `tvalid` is never asserted.
- **First and corner beats** (default parameters, `tready`=1):
  - Beat 0 (h=0, v=0): x=0xC3200000, y=0x42B40000, z=0xC3800000.
  - h=160: x=0x00000000.
  - h=319: x=0x431F0000.
  - v=179: y=0xC2B20000.
  - Beat 0 `tvalid` appears 3 cycles after `start`.
- **Full frame:** `tready`=1 throughout.
  - Exactly 57600 beats in raster order, each matching a software model.
  - `frame_done` pulses once, one cycle after the last beat; `busy` falls with it.
- **Backpressure:** toggle `tready` randomly at 50%.
  - Data is stable during stalls.
  - No beat is lost or duplicated.
  - Beat count is 57600 and order is unchanged.
- **Mask and start-while-busy:**
  - `start` with `select_objs_in`=2'b01: `select_objs` reads 01 on every beat.
  - A second `start` mid-frame with mask 2'b10 is ignored; the mask stays 01 and counters are not disturbed.
- **Reset mid-frame:** assert `areset` at beat 1000.
  - The next cycle `tvalid`=0 and `busy`=0, with no `frame_done`.
  - A fresh `start` restarts from h=0, v=0.
